// File: rtl/pc_btb_fetch_if.sv
// Fetch-side bus of pc_btb_fetch: predicted fetch outputs toward IF/ID and the
// EX-stage BTB training channel.
interface pc_btb_fetch_if;
    logic        upd_en;
    logic [31:0] upd_pc_i;
    logic [31:0] upd_target_i;
    logic        upd_taken_i;
    logic        upd_hit_i;
    logic [2:0]  upd_hitpos_i;
    logic [31:0] PC_o;
    logic [31:0] prepc_o;
    logic        hit_o;
    logic [2:0]  hitpos_o;

    modport slave (
        input  upd_en, upd_pc_i, upd_target_i, upd_taken_i, upd_hit_i, upd_hitpos_i,
        output PC_o, prepc_o, hit_o, hitpos_o
    );

    modport master (
        output upd_en, upd_pc_i, upd_target_i, upd_taken_i, upd_hit_i, upd_hitpos_i,
        input  PC_o, prepc_o, hit_o, hitpos_o
    );
endinterface

// File: rtl/pc_btb_fetch.sv
// Fetch PC generator with an 8-entry fully associative BTB and 2-bit counters.
// Lookup is combinational from the registered PC; training comes from EX.
module pc_btb_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] INT_VECTOR = 32'h0000_0800,
    parameter logic [1:0]  CNT_ALLOC  = 2'b10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        interrupt,
    input  logic        eret,
    input  logic [31:0] epc_i,
    input  logic        jump_rst,
    input  logic [31:0] jump_pc_i,
    input  logic        stall,
    input  logic        halt,
    pc_btb_fetch_if.slave bus
);

    logic [7:0]       valid;
    logic [29:0]      tag    [8];
    logic [31:0]      target [8];
    logic [1:0]       cnt    [8];
    logic [2:0]       rr;
    logic [31:0]      pc;

    logic             hit;
    logic [2:0]       hitpos;
    logic [31:0]      prepc;
    logic [31:0]      pc_next;

    logic             upd_match;
    logic [2:0]       upd_idx;
    logic             upd_existing;
    logic [2:0]       upd_entry;
    logic             unused_ok;

    assign unused_ok = ^bus.upd_pc_i[1:0];

    always_comb begin
        hit    = 1'b0;
        hitpos = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (valid[i] && tag[i] == pc[31:2]) begin
                hit    = 1'b1;
                hitpos = 3'(i);
            end
        end
    end

    always_comb begin
        prepc = pc + 32'd4;
        if (hit && cnt[hitpos][1])
            prepc = target[hitpos];
    end

    // Catches a branch allocated after its own lookup (hit flag from the pipe is stale).
    always_comb begin
        upd_match = 1'b0;
        upd_idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (valid[i] && tag[i] == bus.upd_pc_i[31:2]) begin
                upd_match = 1'b1;
                upd_idx   = 3'(i);
            end
        end
    end

    always_comb begin
        upd_existing = bus.upd_hit_i || upd_match;
        upd_entry    = bus.upd_hit_i ? bus.upd_hitpos_i : upd_idx;
    end

    always_comb begin
        pc_next = prepc;
        if (interrupt)
            pc_next = INT_VECTOR;
        else if (eret)
            pc_next = epc_i;
        else if (jump_rst)
            pc_next = jump_pc_i;
        else if (halt || stall)
            pc_next = pc;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc    <= RESET_PC;
            rr    <= 3'd0;
            valid <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                tag[i]    <= 30'd0;
                target[i] <= 32'd0;
                cnt[i]    <= 2'd0;
            end
        end else begin
            pc <= pc_next;
            if (bus.upd_en) begin
                if (upd_existing) begin
                    if (bus.upd_taken_i) begin
                        if (cnt[upd_entry] != 2'b11)
                            cnt[upd_entry] <= cnt[upd_entry] + 2'b01;
                        target[upd_entry] <= bus.upd_target_i;
                    end else if (cnt[upd_entry] != 2'b00) begin
                        cnt[upd_entry] <= cnt[upd_entry] - 2'b01;
                    end
                end else if (bus.upd_taken_i) begin
                    valid[rr]  <= 1'b1;
                    tag[rr]    <= bus.upd_pc_i[31:2];
                    target[rr] <= bus.upd_target_i;
                    cnt[rr]    <= CNT_ALLOC;
                    rr         <= rr + 3'd1;
                end
            end
        end
    end

    assign bus.PC_o     = pc;
    assign bus.prepc_o  = prepc;
    assign bus.hit_o    = hit;
    assign bus.hitpos_o = hitpos;

endmodule

// File: tb/tb_pc_btb_fetch.sv
// Directed bench for pc_btb_fetch: reset, allocation, counters, replacement,
// redirect priority and same-cycle update/lookup ordering.
module tb_pc_btb_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        interrupt;
    logic        eret;
    logic [31:0] epc_i;
    logic        jump_rst;
    logic [31:0] jump_pc_i;
    logic        stall;
    logic        halt;
    int          tests = 0;
    int          fails = 0;

    pc_btb_fetch_if bus();

    pc_btb_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .interrupt (interrupt),
        .eret      (eret),
        .epc_i     (epc_i),
        .jump_rst  (jump_rst),
        .jump_pc_i (jump_pc_i),
        .stall     (stall),
        .halt      (halt),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_pc(input logic [31:0] a);
        jump_rst  = 1'b1;
        jump_pc_i = a;
        step();
        jump_rst  = 1'b0;
    endtask

    task automatic upd(input logic [31:0] p, input logic [31:0] t, input logic tk,
                       input logic h, input logic [2:0] hp);
        bus.upd_en       = 1'b1;
        bus.upd_pc_i     = p;
        bus.upd_target_i = t;
        bus.upd_taken_i  = tk;
        bus.upd_hit_i    = h;
        bus.upd_hitpos_i = hp;
        step();
        bus.upd_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        tests++; if (bus.PC_o !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h expected %h", bus.PC_o, 32'h0); end
        tests++; if (bus.hit_o !== 1'b0 || bus.hitpos_o !== 3'd0) begin fails++; $display("FAIL reset_hit: got %b/%0d expected 0/0", bus.hit_o, bus.hitpos_o); end
        tests++; if (bus.prepc_o !== 32'h4) begin fails++; $display("FAIL reset_prepc: got %h expected %h", bus.prepc_o, 32'h4); end
        rst = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            tests++; if (bus.PC_o !== 32'(4 * k) || bus.prepc_o !== 32'(4 * k + 4) || bus.hit_o !== 1'b0) begin
                fails++; $display("FAIL freerun_%0d: got pc %h prepc %h hit %b expected pc %h", k, bus.PC_o, bus.prepc_o, bus.hit_o, 32'(4 * k));
            end
        end
        halt = 1'b1;
        goto_pc(32'hFFFF_FFFC);
        tests++; if (bus.prepc_o !== 32'h0) begin fails++; $display("FAIL wrap_prepc: got %h expected %h", bus.prepc_o, 32'h0); end
    endtask

    task automatic test_allocate();
        upd(32'h10, 32'h40, 1'b1, 1'b0, 3'd0);
        goto_pc(32'h10);
        tests++; if (bus.hit_o !== 1'b1 || bus.hitpos_o !== 3'd0 || bus.prepc_o !== 32'h40) begin
            fails++; $display("FAIL alloc_lookup: got hit %b pos %0d prepc %h expected 1 0 00000040", bus.hit_o, bus.hitpos_o, bus.prepc_o);
        end
        halt = 1'b0;
        step();
        tests++; if (bus.PC_o !== 32'h40) begin fails++; $display("FAIL alloc_follow: got %h expected %h", bus.PC_o, 32'h40); end
        halt = 1'b1;
    endtask

    task automatic test_counter();
        upd(32'h10, 32'h40, 1'b0, 1'b1, 3'd0);
        upd(32'h10, 32'h40, 1'b0, 1'b1, 3'd0);
        goto_pc(32'h10);
        tests++; if (bus.hit_o !== 1'b1 || bus.prepc_o !== 32'h14) begin
            fails++; $display("FAIL cnt_down: got hit %b prepc %h expected 1 00000014", bus.hit_o, bus.prepc_o);
        end
        upd(32'h10, 32'h40, 1'b0, 1'b1, 3'd0);
        tests++; if (bus.prepc_o !== 32'h14) begin fails++; $display("FAIL cnt_floor: got %h expected %h", bus.prepc_o, 32'h14); end
        for (int k = 0; k < 4; k++) upd(32'h10, 32'h40, 1'b1, 1'b1, 3'd0);
        upd(32'h10, 32'h40, 1'b0, 1'b1, 3'd0);
        tests++; if (bus.prepc_o !== 32'h40) begin fails++; $display("FAIL cnt_sat_hi: got %h expected %h", bus.prepc_o, 32'h40); end
        upd(32'h10, 32'h40, 1'b0, 1'b1, 3'd0);
        tests++; if (bus.prepc_o !== 32'h14) begin fails++; $display("FAIL cnt_step_down: got %h expected %h", bus.prepc_o, 32'h14); end
        upd(32'h10, 32'h44, 1'b1, 1'b1, 3'd0);
        tests++; if (bus.prepc_o !== 32'h44) begin fails++; $display("FAIL target_update: got %h expected %h", bus.prepc_o, 32'h44); end
    endtask

    task automatic test_replacement();
        do_reset();
        for (int k = 0; k < 9; k++)
            upd(32'h100 + 32'(4 * k), 32'h200 + 32'(4 * k), 1'b1, 1'b0, 3'd0);
        goto_pc(32'h100);
        tests++; if (bus.hit_o !== 1'b0 || bus.prepc_o !== 32'h104) begin
            fails++; $display("FAIL repl_evicted: got hit %b prepc %h expected 0 00000104", bus.hit_o, bus.prepc_o);
        end
        goto_pc(32'h120);
        tests++; if (bus.hit_o !== 1'b1 || bus.hitpos_o !== 3'd0 || bus.prepc_o !== 32'h220) begin
            fails++; $display("FAIL repl_wrap: got hit %b pos %0d prepc %h expected 1 0 00000220", bus.hit_o, bus.hitpos_o, bus.prepc_o);
        end
        goto_pc(32'h11C);
        tests++; if (bus.hit_o !== 1'b1 || bus.hitpos_o !== 3'd7) begin
            fails++; $display("FAIL repl_entry7: got hit %b pos %0d expected 1 7", bus.hit_o, bus.hitpos_o);
        end
        upd(32'h300, 32'h340, 1'b1, 1'b0, 3'd0);
        goto_pc(32'h300);
        tests++; if (bus.hit_o !== 1'b1 || bus.hitpos_o !== 3'd1) begin
            fails++; $display("FAIL repl_rr: got hit %b pos %0d expected 1 1", bus.hit_o, bus.hitpos_o);
        end
        goto_pc(32'h104);
        tests++; if (bus.hit_o !== 1'b0) begin fails++; $display("FAIL repl_evict1: got %b expected 0", bus.hit_o); end
        upd(32'h400, 32'h440, 1'b0, 1'b0, 3'd0);
        upd(32'h404, 32'h444, 1'b1, 1'b0, 3'd0);
        goto_pc(32'h404);
        tests++; if (bus.hitpos_o !== 3'd2) begin fails++; $display("FAIL alloc_nt_skip: got %0d expected 2", bus.hitpos_o); end
    endtask

    task automatic test_priority();
        halt      = 1'b0;
        interrupt = 1'b1;
        eret      = 1'b1;
        epc_i     = 32'h500;
        jump_rst  = 1'b1;
        jump_pc_i = 32'h600;
        stall     = 1'b1;
        step();
        tests++; if (bus.PC_o !== 32'h800) begin fails++; $display("FAIL prio_int: got %h expected %h", bus.PC_o, 32'h800); end
        interrupt = 1'b0;
        step();
        tests++; if (bus.PC_o !== 32'h500) begin fails++; $display("FAIL prio_eret: got %h expected %h", bus.PC_o, 32'h500); end
        eret = 1'b0;
        step();
        tests++; if (bus.PC_o !== 32'h600) begin fails++; $display("FAIL prio_jump: got %h expected %h", bus.PC_o, 32'h600); end
        jump_rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            tests++; if (bus.PC_o !== 32'h600) begin fails++; $display("FAIL stall_hold_%0d: got %h expected %h", k, bus.PC_o, 32'h600); end
        end
        stall = 1'b0;
        halt  = 1'b1;
        step();
        step();
        tests++; if (bus.PC_o !== 32'h600) begin fails++; $display("FAIL halt_hold: got %h expected %h", bus.PC_o, 32'h600); end
        halt = 1'b0;
        step();
        tests++; if (bus.PC_o !== 32'h604) begin fails++; $display("FAIL resume: got %h expected %h", bus.PC_o, 32'h604); end
        halt = 1'b1;
    endtask

    task automatic test_back_to_back();
        bus.upd_en       = 1'b1;
        bus.upd_pc_i     = 32'h40;
        bus.upd_target_i = 32'h80;
        bus.upd_taken_i  = 1'b1;
        bus.upd_hit_i    = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        bus.upd_en = 1'b0;
        goto_pc(32'h40);
        tests++; if (bus.hit_o !== 1'b0) begin fails++; $display("FAIL reset_discard: got %b expected 0", bus.hit_o); end
        upd(32'h20, 32'h80, 1'b1, 1'b0, 3'd0);
        upd(32'h20, 32'h84, 1'b1, 1'b0, 3'd0);
        upd(32'h30, 32'h90, 1'b1, 1'b0, 3'd0);
        goto_pc(32'h30);
        tests++; if (bus.hit_o !== 1'b1 || bus.hitpos_o !== 3'd1) begin
            fails++; $display("FAIL dup_guard: got hit %b pos %0d expected 1 1", bus.hit_o, bus.hitpos_o);
        end
        goto_pc(32'h20);
        tests++; if (bus.hitpos_o !== 3'd0 || bus.prepc_o !== 32'h84) begin
            fails++; $display("FAIL dup_retrain: got pos %0d prepc %h expected 0 00000084", bus.hitpos_o, bus.prepc_o);
        end
        goto_pc(32'h28);
        bus.upd_en       = 1'b1;
        bus.upd_pc_i     = 32'h28;
        bus.upd_target_i = 32'hA0;
        bus.upd_taken_i  = 1'b1;
        bus.upd_hit_i    = 1'b0;
        #2;
        tests++; if (bus.hit_o !== 1'b0 || bus.prepc_o !== 32'h2C) begin
            fails++; $display("FAIL same_cycle: got hit %b prepc %h expected 0 0000002c", bus.hit_o, bus.prepc_o);
        end
        step();
        bus.upd_en = 1'b0;
        tests++; if (bus.hit_o !== 1'b1 || bus.hitpos_o !== 3'd2 || bus.prepc_o !== 32'hA0) begin
            fails++; $display("FAIL next_cycle: got hit %b pos %0d prepc %h expected 1 2 000000a0", bus.hit_o, bus.hitpos_o, bus.prepc_o);
        end
        halt = 1'b0;
        jump_rst  = 1'b1;
        jump_pc_i = 32'h700;
        upd(32'h28, 32'hA0, 1'b0, 1'b1, 3'd2);
        tests++; if (bus.PC_o !== 32'h700) begin fails++; $display("FAIL redirect_train_pc: got %h expected %h", bus.PC_o, 32'h700); end
        jump_rst = 1'b0;
        halt = 1'b1;
        goto_pc(32'h28);
        tests++; if (bus.hit_o !== 1'b1 || bus.prepc_o !== 32'h2C) begin
            fails++; $display("FAIL redirect_train_cnt: got hit %b prepc %h expected 1 0000002c", bus.hit_o, bus.prepc_o);
        end
    endtask

    initial begin
        rst              = 1'b0;
        interrupt        = 1'b0;
        eret             = 1'b0;
        epc_i            = 32'h0;
        jump_rst         = 1'b0;
        jump_pc_i        = 32'h0;
        stall            = 1'b0;
        halt             = 1'b0;
        bus.upd_en       = 1'b0;
        bus.upd_pc_i     = 32'h0;
        bus.upd_target_i = 32'h0;
        bus.upd_taken_i  = 1'b0;
        bus.upd_hit_i    = 1'b0;
        bus.upd_hitpos_i = 3'd0;
        #1;
        test_reset();
        test_allocate();
        test_counter();
        test_replacement();
        test_priority();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_btb_fetch.md
Name: pc_btb_fetch

Overview:
- Fetch-stage PC generator with dynamic branch prediction.
- Holds the architectural fetch PC and looks it up in an 8-entry fully associative branch target buffer (BTB). Each entry carries a 2-bit saturating counter.
- Drives PC, predicted next PC, hit flag and hit position directly into the IF/ID pipeline register.
- The EX stage trains the BTB and issues mispredict redirects.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC after reset.
- INT_VECTOR, 32'h0000_0800, fetch PC loaded on interrupt.
- CNT_ALLOC, 2'b10, counter value written on new allocation (weakly taken).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- interrupt  in  1  redirect fetch to INT_VECTOR.
- eret  in  1  redirect fetch to epc_i.
- epc_i  in  32  exception return address.
- jump_rst  in  1  EX-stage mispredict redirect.
- jump_pc_i  in  32  correct PC for the redirect.
- stall  in  1  hold PC (load-use hazard).
- halt  in  1  hold PC (CPU halted).
- upd_en  in  1  EX-stage branch/jump resolved this cycle.
- upd_pc_i  in  32  PC of the resolved instruction.
- upd_target_i  in  32  resolved target.
- upd_taken_i  in  1  branch actually taken.
- upd_hit_i  in  1  hit flag that travelled down the pipe with the instruction.
- upd_hitpos_i  in  3  hit position that travelled down the pipe.
- PC_o  out  32  current fetch PC (registered).
- prepc_o  out  32  predicted next PC (combinational from PC_o and BTB state).
- hit_o  out  1  PC_o matched a valid BTB entry.
- hitpos_o  out  3  index of the matching entry.

Behaviour:
- BTB storage, per entry i (0..7): valid, tag[29:0] = PC[31:2], target[31:0], cnt[1:0].
- Replacement: round-robin pointer rr[2:0].
- Reset (rst==0 at posedge):
  - PC_o=RESET_PC.
  - All valid=0, cnt=0, targets and tags cleared, rr=0.
  - Outputs after reset: hit_o=0, hitpos_o=0, prepc_o=RESET_PC+4.
- Lookup (combinational, zero latency, from PC_o):
  - match_i = valid_i && tag_i==PC_o[31:2].
  - At most one match exists (guaranteed by the allocation rule below); hitpos_o = index of the match.
  - On a miss: hit_o=0, hitpos_o=0.
- Prediction:
  - prepc_o = target_hitpos when hit_o && cnt_hitpos[1].
  - Otherwise prepc_o = PC_o+4 (32-bit wrap; 32'hFFFF_FFFC+4 = 0).
- Next-PC priority at posedge, highest first:
  1. rst==0 → RESET_PC.
  2. interrupt → INT_VECTOR.
  3. eret → epc_i.
  4. jump_rst → jump_pc_i.
  5. halt → hold.
  6. stall → hold.
  7. else → prepc_o.
- Training (at posedge, when upd_en && rst==1; independent of stall, halt and redirects):
  - Target entry:
    - If upd_hit_i: entry e = upd_hitpos_i.
    - Else, if upd_pc_i already matches a valid entry (allocated since the lookup): e = that entry.
    - Else: allocation case.
  - Existing entry e, taken:
    - cnt_e saturates up, 3 stays 3.
    - target_e = upd_target_i.
  - Existing entry e, not taken: cnt_e saturates down, 0 stays 0; target unchanged.
  - Allocation, taken only:
    - Entry rr gets valid=1, tag=upd_pc_i[31:2], target=upd_target_i, cnt=CNT_ALLOC.
    - rr increments mod 8; valid entries are overwritten.
  - Allocation, not taken: no write, rr unchanged.
- Update/lookup in the same cycle: the lookup uses pre-edge state. A write to the entry matching PC_o takes effect on the next cycle's lookup.
- Reset mid-operation: a pending upd_en in the reset cycle is discarded; all state is cleared.
- Redirect and training in the same cycle (normal mispredict case): both happen; PC takes the redirect.

Test Plan:
- Reset then free-run: rst=0 for 2 cycles, release → PC_o sequence 0,4,8,C; hit_o=0; prepc_o=PC_o+4.
- Allocate and predict:
  - Stimulus: upd_en, upd_pc_i=0x10, upd_target_i=0x40, upd_taken_i=1, upd_hit_i=0.
  - Response: entry 0 allocated, cnt=2.
  - When PC_o reaches 0x10: hit_o=1, hitpos_o=0, prepc_o=0x40; next PC_o=0x40.
- Counter saturation:
  - Two not-taken updates on entry 0 → cnt 2→1→0; PC 0x10 gives hit_o=1, prepc_o=0x14.
  - Four taken updates → cnt=3, and it stays 3.
- Replacement wrap:
  - 9 taken allocations at PCs 0x100..0x120 step 4.
  - Entry 0 now holds tag 0x120>>2; PC 0x100 misses (hit_o=0); rr=1.
- Priority:
  - interrupt, eret, jump_rst and stall all asserted → PC_o=0x800.
  - Drop interrupt → PC_o=epc_i.
  - Drop eret → PC_o=jump_pc_i.
  - stall alone → PC_o held for 3 cycles.
  - halt alone → PC_o held.
- Duplicate guard plus concurrency:
  - Two taken updates with upd_hit_i=0 for the same upd_pc_i=0x20 on consecutive cycles → one entry only, rr advances by 1.
  - An update while PC_o=0x20 → hit_o changes on the following cycle, not the same one.
